// File: rtl/seg7_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver: segment table,
// state encoding and inactive-level helpers.
package seg7_scan_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } state_t;

    // Active-high segment patterns, bit 0 = segment a, bit 6 = segment g.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_off(input bit act_low);
        return act_low ? 7'h7F : 7'h00;
    endfunction

    function automatic logic an_off_bit(input bit act_low);
        return act_low;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-high 7-segment pattern (bit 0 = a).
// Purely combinational, zero latency.
module seg7_hex_decode
    import seg7_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_ah
);

    always_comb begin
        seg_ah = HEX_SEG[nib];
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment scanner: shadows smg_val once per frame, lights
// each digit for CLK_DIV cycles with BLANK_CYC dark cycles between digits.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int NDIG        = 3,
    parameter int CLK_DIV     = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4*NDIG-1:0] smg_val,
    input  logic              lz_en,
    input  logic [NDIG-1:0]   dp_mask,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [NDIG-1:0]   an,
    output logic              frame_done
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CW-1:0]   ON_LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(NDIG - 1);
    localparam logic [6:0]      SEG_OFF    = seg_off(SEG_ACT_LOW != 0);
    localparam logic            DP_OFF     = (SEG_ACT_LOW != 0);
    localparam logic [NDIG-1:0] AN_OFF     = {NDIG{an_off_bit(AN_ACT_LOW != 0)}};

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*NDIG-1:0]   shadow;

    logic [3:0]          nib;
    logic [6:0]          dec_seg;
    logic                suppress;
    logic                dp_sel;
    logic [NDIG-1:0]     an_act;
    logic [6:0]          seg_drv;
    logic                dp_drv;
    logic [NDIG-1:0]     an_drv;

    // Select the nibble, dp and anode for the current index; suppression blanks
    // a non-zero-index digit when it and every higher shadow nibble are zero.
    always_comb begin
        nib      = '0;
        dp_sel   = 1'b0;
        an_act   = '0;
        suppress = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (IW'(i) == idx) begin
                nib       = shadow[4*i +: 4];
                dp_sel    = dp_mask[i];
                an_act[i] = 1'b1;
                if (i > 0) begin
                    suppress = lz_en && ((shadow >> (4*i)) == '0);
                end
            end
        end
    end

    seg7_hex_decode u_dec (
        .nib    (nib),
        .seg_ah (dec_seg)
    );

    // Polarity is the last stage before the output registers.
    always_comb begin
        seg_drv = (suppress ? 7'h00 : dec_seg) ^ SEG_OFF;
        dp_drv  = dp_sel ^ DP_OFF;
        an_drv  = an_act ^ AN_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_BLANK;
            cnt        <= '0;
            idx        <= '0;
            shadow     <= '0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= S_ON;
                        cnt   <= '0;
                        an    <= an_drv;
                        seg   <= seg_drv;
                        dp    <= dp_drv;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ON: begin
                    if (cnt == ON_LAST) begin
                        state <= S_BLANK;
                        cnt   <= '0;
                        an    <= AN_OFF;
                        seg   <= SEG_OFF;
                        dp    <= DP_OFF;
                        if (idx == IDX_LAST) begin
                            idx        <= '0;
                            shadow     <= smg_val;
                            frame_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        // lz_en and dp_mask are live, so keep refreshing while lit.
                        cnt <= cnt + 1'b1;
                        an  <= an_drv;
                        seg <= seg_drv;
                        dp  <= dp_drv;
                    end
                end
            endcase
        end
    end

endmodule
